// File: rtl/tx_pingpong_arb.sv
// ============================================================================
// Module   : tx_pingpong_arb
// Brief    : Two-producer arbiter owning the 2-page TX ping-pong buffer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tx_pingpong_arb #(
    parameter int ADDR_NBIT = 8,
    parameter int DATA_NBIT = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [1:0]           req,
    output logic [1:0]           gnt,
    input  logic [1:0]           wr_vd,
    input  logic [ADDR_NBIT-1:0] wr_addr0,
    input  logic [ADDR_NBIT-1:0] wr_addr1,
    input  logic [DATA_NBIT-1:0] wr_data0,
    input  logic [DATA_NBIT-1:0] wr_data1,
    input  logic [1:0]           done,
    output logic                 buf_wren,
    output logic [ADDR_NBIT:0]   buf_wraddr,
    output logic [DATA_NBIT-1:0] buf_wrdata,
    output logic                 tx_eop,
    output logic                 tx_page,
    input  logic                 page_free,
    output logic [1:0]           busy,
    output logic                 err
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_OWN    = 2'd1;
    localparam logic [1:0] S_COMMIT = 2'd2;

    logic [1:0]           r_state;
    logic [1:0]           r_gnt;
    logic                 r_g;
    logic                 r_rr_last;
    logic                 r_wr_page;
    logic [1:0]           r_busy;
    logic                 r_err;
    logic                 r_tx_eop;
    logic                 r_tx_page;
    logic                 r_buf_wren;
    logic [ADDR_NBIT:0]   r_buf_wraddr;
    logic [DATA_NBIT-1:0] r_buf_wrdata;
    logic                 r_q0;
    logic                 r_q1;
    logic [1:0]           r_qcnt;

    logic                 w_winner;
    logic                 w_own;
    logic                 w_stray_wr;
    logic                 w_stray_done;
    logic                 w_free_bad;
    logic                 w_pop;
    logic                 w_push;
    logic [1:0]           w_rel_mask;
    logic [1:0]           w_set_mask;
    logic [ADDR_NBIT-1:0] w_addr_g;
    logic [DATA_NBIT-1:0] w_data_g;

    // Both requesting: the producer that did not win last time goes next.
    assign w_winner     = (req == 2'b11) ? ~r_rr_last : req[1];
    assign w_own        = (r_state == S_OWN);
    assign w_stray_wr   = w_own ? wr_vd[~r_g] : (wr_vd != 2'b00);
    assign w_stray_done = w_own ? done[~r_g]  : (done != 2'b00);
    assign w_free_bad   = page_free && (r_busy == 2'b00);
    assign w_pop        = page_free && (r_busy != 2'b00);
    assign w_push       = (r_state == S_COMMIT);
    assign w_rel_mask   = w_pop  ? (r_q0 ? 2'b10 : 2'b01) : 2'b00;
    assign w_set_mask   = w_push ? (r_wr_page ? 2'b10 : 2'b01) : 2'b00;
    assign w_addr_g     = r_g ? wr_addr1 : wr_addr0;
    assign w_data_g     = r_g ? wr_data1 : wr_data0;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_gnt        <= 2'b00;
            r_g          <= 1'b0;
            r_rr_last    <= 1'b1;
            r_wr_page    <= 1'b0;
            r_busy       <= 2'b00;
            r_err        <= 1'b0;
            r_tx_eop     <= 1'b0;
            r_tx_page    <= 1'b0;
            r_buf_wren   <= 1'b0;
            r_buf_wraddr <= '0;
            r_buf_wrdata <= '0;
            r_q0         <= 1'b0;
            r_q1         <= 1'b0;
            r_qcnt       <= 2'd0;
        end else begin
            r_buf_wren <= 1'b0;
            r_tx_eop   <= 1'b0;

            if (w_stray_wr || w_stray_done || w_free_bad) begin
                r_err <= 1'b1;
            end

            // Release and commit are independent bits, so both land in one cycle.
            r_busy <= (r_busy & ~w_rel_mask) | w_set_mask;

            case ({w_push, w_pop})
                2'b10: begin
                    if (r_qcnt == 2'd0) r_q0 <= r_wr_page;
                    else                r_q1 <= r_wr_page;
                    r_qcnt <= r_qcnt + 2'd1;
                end
                2'b01: begin
                    r_q0   <= r_q1;
                    r_qcnt <= r_qcnt - 2'd1;
                end
                2'b11: begin
                    if (r_qcnt == 2'd1) begin
                        r_q0 <= r_wr_page;
                    end else begin
                        r_q0 <= r_q1;
                        r_q1 <= r_wr_page;
                    end
                end
                default: ;
            endcase

            case (r_state)
                S_IDLE: begin
                    if ((req != 2'b00) && !r_busy[r_wr_page]) begin
                        r_gnt     <= w_winner ? 2'b10 : 2'b01;
                        r_g       <= w_winner;
                        r_rr_last <= w_winner;
                        r_state   <= S_OWN;
                    end
                end
                S_OWN: begin
                    if (wr_vd[r_g]) begin
                        r_buf_wren   <= 1'b1;
                        r_buf_wraddr <= {r_wr_page, w_addr_g};
                        r_buf_wrdata <= w_data_g;
                    end
                    // A request dropped without done abandons the page uncommitted.
                    if (done[r_g]) begin
                        r_gnt   <= 2'b00;
                        r_state <= S_COMMIT;
                    end else if (!req[r_g]) begin
                        r_gnt   <= 2'b00;
                        r_state <= S_IDLE;
                    end
                end
                S_COMMIT: begin
                    r_tx_eop  <= 1'b1;
                    r_tx_page <= r_wr_page;
                    r_wr_page <= ~r_wr_page;
                    r_state   <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign gnt        = r_gnt;
    assign buf_wren   = r_buf_wren;
    assign buf_wraddr = r_buf_wraddr;
    assign buf_wrdata = r_buf_wrdata;
    assign tx_eop     = r_tx_eop;
    assign tx_page    = r_tx_page;
    assign busy       = r_busy;
    assign err        = r_err;

endmodule

`default_nettype wire

// File: tb/tb_tx_pingpong_arb.sv
// ============================================================================
// Module   : tb_tx_pingpong_arb
// Brief    : Scoreboard bench for tx_pingpong_arb with directed packet vectors.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_tx_pingpong_arb;

    localparam int AW = 8;
    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [1:0]    req = 2'b00;
    logic [1:0]    wr_vd = 2'b00;
    logic [1:0]    done = 2'b00;
    logic [AW-1:0] wr_addr0 = '0;
    logic [AW-1:0] wr_addr1 = '0;
    logic [DW-1:0] wr_data0 = '0;
    logic [DW-1:0] wr_data1 = '0;
    logic          page_free = 1'b0;

    logic [1:0]    gnt;
    logic [1:0]    busy;
    logic          buf_wren;
    logic [AW:0]   buf_wraddr;
    logic [DW-1:0] buf_wrdata;
    logic          tx_eop;
    logic          tx_page;
    logic          err;

    int total = 0;
    int bad   = 0;
    int lat   = 0;

    logic [AW:0]   qa[$];
    logic [DW-1:0] qd[$];
    logic          qe[$];
    logic          prev_wren = 1'b0;

    tx_pingpong_arb #(.ADDR_NBIT(AW), .DATA_NBIT(DW)) dut (
        .clk(clk), .rst(rst), .req(req), .gnt(gnt), .wr_vd(wr_vd),
        .wr_addr0(wr_addr0), .wr_addr1(wr_addr1),
        .wr_data0(wr_data0), .wr_data1(wr_data1), .done(done),
        .buf_wren(buf_wren), .buf_wraddr(buf_wraddr), .buf_wrdata(buf_wrdata),
        .tx_eop(tx_eop), .tx_page(tx_page), .page_free(page_free),
        .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: pops the expectation queues whenever the DUT emits a write or commit.
    always @(negedge clk) begin
        if (buf_wren === 1'b1) begin
            if (qa.size() == 0) begin
                total++; bad++;
                $display("FAIL unexpected_write: got addr %0h data %0h expected none", buf_wraddr, buf_wrdata);
            end else begin
                chk("wr_addr", 32'(buf_wraddr), 32'(qa.pop_front()));
                chk("wr_data", 32'(buf_wrdata), 32'(qd.pop_front()));
            end
        end
        if (tx_eop === 1'b1) begin
            if (qe.size() == 0) begin
                total++; bad++;
                $display("FAIL unexpected_eop: got page %0d expected none", tx_page);
            end else begin
                chk("tx_page", 32'(tx_page), 32'(qe.pop_front()));
                chk("eop_after_wr", 32'(prev_wren), 32'd1);
            end
        end
        prev_wren = buf_wren;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish expected finish before timeout");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        req = 2'b00; wr_vd = 2'b00; done = 2'b00; page_free = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic wait_gnt(input string name, input logic [1:0] exp, input int max, output int n);
        n = 0;
        for (int k = 1; k <= max; k++) begin
            tick();
            if (gnt != 2'b00) begin
                n = k;
                break;
            end
        end
        if (n == 0) begin
            total++; bad++;
            $display("FAIL %s: got no grant in %0d cycles expected %b", name, max, exp);
        end else begin
            chk(name, 32'(gnt), 32'(exp));
        end
    endtask

    task automatic run_pkt(input int p, input logic page, input int n, input logic [DW-1:0] base,
                           input bit do_done, input bit keep_req, input bit free_at_commit);
        for (int i = 0; i < n; i++) begin
            wr_vd = 2'b00;
            wr_vd[p] = 1'b1;
            if (p == 0) begin wr_addr0 = AW'(i); wr_data0 = base + DW'(i); end
            else        begin wr_addr1 = AW'(i); wr_data1 = base + DW'(i); end
            qa.push_back({page, AW'(i)});
            qd.push_back(base + DW'(i));
            if (do_done && (i == n - 1)) begin
                done[p] = 1'b1;
                qe.push_back(page);
            end
            tick();
        end
        wr_vd = 2'b00;
        done  = 2'b00;
        if (!do_done) begin
            req[p] = 1'b0;
            tick();
            chk("abort_gnt", 32'(gnt), 32'd0);
        end else begin
            if (!keep_req) req[p] = 1'b0;
            chk("gnt_drop", 32'(gnt), 32'd0);
            page_free = free_at_commit;
            tick();
            page_free = 1'b0;
        end
    endtask

    initial begin
        // Reset values
        repeat (2) tick();
        chk("rst_gnt", 32'(gnt), 32'd0);
        chk("rst_wren", 32'(buf_wren), 32'd0);
        chk("rst_addr", 32'(buf_wraddr), 32'd0);
        chk("rst_data", 32'(buf_wrdata), 32'd0);
        chk("rst_eop", 32'(tx_eop), 32'd0);
        chk("rst_txpage", 32'(tx_page), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        rst = 1'b0;

        // Single packet, producer 0, page 0
        req[0] = 1'b1;
        wait_gnt("gnt_p0", 2'b01, 5, lat);
        chk("gnt_latency", 32'(lat), 32'd1);
        run_pkt(0, 1'b0, 4, 16'hA000, 1, 0, 0);
        chk("busy_pkt1", 32'(busy), 32'h1);
        chk("txpage_pkt1", 32'(tx_page), 32'd0);

        // Second packet lands on page 1
        req[1] = 1'b1;
        wait_gnt("gnt_p1", 2'b10, 5, lat);
        run_pkt(1, 1'b1, 3, 16'hB000, 1, 0, 0);
        chk("busy_pkt2", 32'(busy), 32'h3);
        chk("txpage_pkt2", 32'(tx_page), 32'd1);

        // Both pages full: grant waits for page_free
        req[0] = 1'b1;
        repeat (4) tick();
        chk("blocked_gnt", 32'(gnt), 32'd0);
        page_free = 1'b1;
        tick();
        page_free = 1'b0;
        chk("busy_after_free", 32'(busy), 32'h2);
        wait_gnt("gnt_after_free", 2'b01, 5, lat);
        run_pkt(0, 1'b0, 2, 16'hC000, 1, 0, 0);
        chk("busy_pkt3", 32'(busy), 32'h3);
        chk("txpage_pkt3", 32'(tx_page), 32'd0);

        page_free = 1'b1;
        tick();
        page_free = 1'b0;
        chk("busy_free_oldest", 32'(busy), 32'h1);

        // page_free coincident with commit
        req[1] = 1'b1;
        wait_gnt("gnt_sim", 2'b10, 5, lat);
        run_pkt(1, 1'b1, 2, 16'hD000, 1, 0, 1);
        chk("busy_sim", 32'(busy), 32'h2);
        chk("txpage_sim", 32'(tx_page), 32'd1);
        chk("err_sim", 32'(err), 32'd0);

        // Abort leaves page 0 uncommitted, then it is reused
        req[1] = 1'b1;
        wait_gnt("gnt_abort", 2'b10, 5, lat);
        run_pkt(1, 1'b0, 3, 16'hE000, 0, 0, 0);
        chk("busy_abort", 32'(busy), 32'h2);
        chk("txpage_abort", 32'(tx_page), 32'd1);
        req[0] = 1'b1;
        wait_gnt("gnt_reuse", 2'b01, 5, lat);
        run_pkt(0, 1'b0, 1, 16'hF000, 1, 0, 0);
        chk("busy_reuse", 32'(busy), 32'h3);
        chk("txpage_reuse", 32'(tx_page), 32'd0);
        page_free = 1'b1;
        tick();
        tick();
        page_free = 1'b0;
        chk("busy_drained", 32'(busy), 32'h0);
        chk("err_clean", 32'(err), 32'd0);

        // Round-robin with both producers requesting continuously
        do_reset();
        req = 2'b11;
        for (int k = 0; k < 4; k++) begin
            wait_gnt("rr_gnt", (k % 2 == 1) ? 2'b10 : 2'b01, 5, lat);
            run_pkt(k % 2, 1'(k % 2), 1, DW'(16'h5000 + 16 * k), 1, 1, k > 0);
            chk("rr_busy", 32'(busy), (k % 2 == 1) ? 32'h2 : 32'h1);
        end
        req = 2'b00;
        chk("rr_err", 32'(err), 32'd0);

        // Error sources
        do_reset();
        page_free = 1'b1;
        tick();
        page_free = 1'b0;
        chk("err_free_empty", 32'(err), 32'd1);
        chk("busy_free_empty", 32'(busy), 32'd0);
        do_reset();
        chk("err_cleared", 32'(err), 32'd0);
        done = 2'b01;
        tick();
        done = 2'b00;
        chk("err_stray_done", 32'(err), 32'd1);
        do_reset();
        req[0] = 1'b1;
        wait_gnt("gnt_err", 2'b01, 5, lat);
        wr_vd = 2'b10; wr_addr1 = 8'h05; wr_data1 = 16'h1234;
        tick();
        wr_vd = 2'b00;
        chk("err_other_wr", 32'(err), 32'd1);
        chk("no_other_write", 32'(buf_wren), 32'd0);

        // Reset while a producer owns the buffer
        req = 2'b00;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midrst_gnt", 32'(gnt), 32'd0);
        chk("midrst_err", 32'(err), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_txpage", 32'(tx_page), 32'd0);
        chk("midrst_wren", 32'(buf_wren), 32'd0);
        chk("midrst_eop", 32'(tx_eop), 32'd0);

        tick();
        chk("wr_queue_left", 32'(qa.size()), 32'd0);
        chk("eop_queue_left", 32'(qe.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
